// File: rtl/uart_bus_port_pkg.sv
// Shared definitions for the memory-mapped UART: register selects, STATUS layout,
// CTRL master-reset code and the TX/RX state types.
package uart_bus_port_pkg;

  localparam logic REG_STATUS = 1'b0;
  localparam logic REG_DATA   = 1'b1;

  localparam int unsigned ST_RDRF = 0;
  localparam int unsigned ST_TDRE = 1;
  localparam int unsigned ST_FE   = 4;
  localparam int unsigned ST_OVR  = 5;

  localparam logic [1:0] CTRL_MRESET = 2'b11;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  function automatic logic [15:0] status_word(input logic ovr, input logic fe,
                                              input logic tdre, input logic rdrf);
    logic [15:0] s;
    s          = '0;
    s[ST_OVR]  = ovr;
    s[ST_FE]   = fe;
    s[ST_TDRE] = tdre;
    s[ST_RDRF] = rdrf;
    return s;
  endfunction

endpackage

// File: rtl/uart_bus_port_if.sv
// CPU-side register bus of the UART: one-cycle select, register select, write strobe, data.
interface uart_bus_port_if;
  logic        sel;
  logic        rsel;
  logic        we;
  logic [15:0] di;
  logic [15:0] dout;

  modport master (output sel, rsel, we, di, input dout);
  modport slave  (input sel, rsel, we, di, output dout);
endinterface

// File: rtl/uart_bus_port_rx_core.sv
// UART receiver: 2-flop synchronizer, mid-bit sampling FSM and bit timer.
// Delivers each 8N1 byte with a one-cycle rx_valid pulse and its framing-error flag.
module uart_rx_core
  import uart_bus_port_pkg::*;
#(
  parameter int unsigned DIVISOR = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_ferr
);

  localparam logic [15:0] BIT_LAST  = 16'(DIVISOR - 1);
  localparam logic [15:0] HALF_LAST = 16'(DIVISOR / 2 - 1);

  logic        sync1, sync2, prev;
  rx_state_t   state;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      prev     <= 1'b1;
      state    <= RX_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      rx_byte  <= '0;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      sync1    <= rxd;
      sync2    <= sync1;
      prev     <= sync2;
      rx_valid <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (prev && !sync2) begin
            cnt   <= '0;
            state <= RX_START;
          end
        end
        RX_START: begin
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            // A start bit that is high again at mid-bit was only a glitch.
            state   <= sync2 ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        RX_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            shift   <= {sync2, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= RX_STOP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        RX_STOP: begin
          if (cnt == BIT_LAST) begin
            cnt      <= '0;
            rx_byte  <= shift;
            rx_ferr  <= ~sync2;
            rx_valid <= 1'b1;
            state    <= RX_IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_bus_port.sv
// Memory-mapped 8N1 UART console: STATUS/CTRL and DATA registers, single-byte
// buffering each way, transmit FSM here and receive path in uart_rx_core.
module uart_bus_port
  import uart_bus_port_pkg::*;
#(
  parameter int unsigned DIVISOR = 434
) (
  input  logic              clk,
  input  logic              reset,
  uart_bus_port_if.slave    bus,
  input  logic              rxd,
  output logic              txd
);

  localparam logic [15:0] BIT_LAST = 16'(DIVISOR - 1);

  logic        data_rd, data_wr, ctrl_wr, any_rd, mreset, uart_rst;
  logic [7:0]  rx_byte;
  logic        rx_valid, rx_ferr;
  logic [7:0]  rx_hold, tx_hold, tx_shift;
  logic        rdrf, tdre, fe, ovr;
  logic [15:0] dout;
  tx_state_t   tx_state;
  logic [15:0] tx_cnt;
  logic [2:0]  tx_bit;
  logic        unused_di;

  assign any_rd    = bus.sel & ~bus.we;
  assign data_rd   = any_rd & (bus.rsel == REG_DATA);
  assign data_wr   = bus.sel & bus.we & (bus.rsel == REG_DATA);
  assign ctrl_wr   = bus.sel & bus.we & (bus.rsel == REG_STATUS);
  assign mreset    = ctrl_wr & (bus.di[1:0] == CTRL_MRESET);
  assign uart_rst  = reset | mreset;
  assign bus.dout  = dout;
  assign unused_di = ^bus.di[15:8];

  uart_rx_core #(.DIVISOR(DIVISOR)) u_rx (
    .clk      (clk),
    .reset    (uart_rst),
    .rxd      (rxd),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .rx_ferr  (rx_ferr)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      dout <= '0;
    end else if (any_rd) begin
      dout <= (bus.rsel == REG_DATA) ? {8'h00, rx_hold} : status_word(ovr, fe, tdre, rdrf);
    end
  end

  // A DATA read clears the flags, but a byte landing in the same cycle re-arms them.
  always_ff @(posedge clk) begin
    if (uart_rst) begin
      rdrf    <= 1'b0;
      fe      <= 1'b0;
      ovr     <= 1'b0;
      rx_hold <= '0;
    end else begin
      if (data_rd) begin
        rdrf <= 1'b0;
        fe   <= 1'b0;
        ovr  <= 1'b0;
      end
      if (rx_valid) begin
        rx_hold <= rx_byte;
        rdrf    <= 1'b1;
        if (rx_ferr) fe <= 1'b1;
        if (rdrf && !data_rd) ovr <= 1'b1;
      end
    end
  end

  // TDRE is cleared only by a write while 1 and set only by the idle load while 0,
  // so the two updates below can never collide.
  always_ff @(posedge clk) begin
    if (uart_rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_hold  <= '0;
      tdre     <= 1'b1;
      txd      <= 1'b1;
    end else begin
      if (data_wr && tdre) begin
        tx_hold <= bus.di[7:0];
        tdre    <= 1'b0;
      end
      case (tx_state)
        TX_IDLE: begin
          if (!tdre) begin
            tx_shift <= tx_hold;
            tdre     <= 1'b1;
            txd      <= 1'b0;
            tx_cnt   <= '0;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            txd      <= tx_shift[0];
            tx_state <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
        TX_DATA: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (tx_bit == 3'd7) begin
              txd      <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              txd      <= tx_shift[1];
              tx_shift <= {1'b0, tx_shift[7:1]};
              tx_bit   <= tx_bit + 3'd1;
            end
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
        TX_STOP: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            tx_state <= TX_IDLE;
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule
